// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the programmable synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, registered or asynchronous read.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int REG_RD = 1,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (REG_RD != 0) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst)     rdata <= '0;
                else if (re) rdata <= mem[raddr];
            end
        end else begin : g_async
            assign rdata = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with optional FWFT read, programmable almost flags,
// synchronous flush and sticky overflow/underflow flags.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int FWFT  = FIFO_STD,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    input  logic [AW:0]      af_thresh,
    input  logic [AW:0]      ae_thresh,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_acc, rd_acc;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    // Flush suppresses both ports so nothing is stored or popped that cycle.
    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A fresh error in the same cycle as err_clr keeps the flag set.
            overflow  <= (wr_en & full)  | (overflow  & ~err_clr);
            underflow <= (rd_en & empty) | (underflow & ~err_clr);
        end
    end

    fifo_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .REG_RD((FWFT == FIFO_FWFT) ? 0 : 1)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(data_in),
        .re   (rd_acc),
        .raddr(rd_ptr),
        .rdata(data_out)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign data_valid = ~empty;
        end else begin : g_std
            logic [1:0] vld_pipe;
            assign vld_pipe[0] = rd_acc;
            always_ff @(posedge clk) begin
                if (rst) vld_pipe[1] <= 1'b0;
                else     vld_pipe[1] <= vld_pipe[0];
            end
            assign data_valid = vld_pipe[1];
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog: standard and FWFT instances on shared stimulus.
module tb_fifo_sync_prog;

    logic       clk = 1'b0;
    logic       rst, flush, wr_en, rd_en, err_clr;
    logic [7:0] data_in;
    logic [3:0] af_thresh, ae_thresh;

    logic [7:0] s_dout, f_dout;
    logic       s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0] s_cnt, f_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fifo_sync_prog #(.WIDTH(8), .DEPTH(8), .FWFT(0)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
        .data_out(s_dout), .data_valid(s_dv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_udf));

    fifo_sync_prog #(.WIDTH(8), .DEPTH(8), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
        .data_out(f_dout), .data_valid(f_dv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_udf));

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        af_thresh = 4'd6; ae_thresh = 4'd1;
        do_reset();
        nvec++; if (s_cnt !== 4'd0)   begin nerr++; $display("FAIL reset_count got %0d want 0", s_cnt); end
        nvec++; if (s_empty !== 1'b1) begin nerr++; $display("FAIL reset_empty got %b want 1", s_empty); end
        nvec++; if (s_full !== 1'b0)  begin nerr++; $display("FAIL reset_full got %b want 0", s_full); end
        nvec++; if (s_dv !== 1'b0)    begin nerr++; $display("FAIL reset_dv got %b want 0", s_dv); end
        nvec++; if (s_dout !== 8'h00) begin nerr++; $display("FAIL reset_dout got %h want 00", s_dout); end
        nvec++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin nerr++; $display("FAIL reset_err got %b%b want 00", s_ovf, s_udf); end
        nvec++; if (s_ae !== 1'b1 || s_af !== 1'b0) begin nerr++; $display("FAIL reset_almost got ae=%b af=%b want ae=1 af=0", s_ae, s_af); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        do_reset();
        wr_en = 1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(8'h11 * (i + 1));
            step();
        end
        nvec++; if (s_full !== 1'b1 || s_cnt !== 4'd8) begin nerr++; $display("FAIL fill_full got full=%b cnt=%0d want 1/8", s_full, s_cnt); end
        nvec++; if (s_ovf !== 1'b0) begin nerr++; $display("FAIL fill_ovf_early got %b want 0", s_ovf); end
        data_in = 8'h99;
        step();
        nvec++; if (s_ovf !== 1'b1 || s_cnt !== 4'd8) begin nerr++; $display("FAIL extra_write got ovf=%b cnt=%0d want 1/8", s_ovf, s_cnt); end
        wr_en = 0; rd_en = 1;
        for (int i = 0; i < 8; i++) begin
            exp = 8'(8'h11 * (i + 1));
            step();
            nvec++; if (s_dout !== exp || s_dv !== 1'b1) begin nerr++; $display("FAIL drain_%0d got %h dv=%b want %h dv=1", i, s_dout, s_dv, exp); end
        end
        rd_en = 0;
        step();
        nvec++; if (s_empty !== 1'b1 || s_dv !== 1'b0) begin nerr++; $display("FAIL drain_end got empty=%b dv=%b want 1/0", s_empty, s_dv); end
        nvec++; if (s_dout !== 8'h88) begin nerr++; $display("FAIL drain_hold got %h want 88", s_dout); end
    endtask

    task automatic test_fwft();
        do_reset();
        nvec++; if (f_dv !== 1'b0) begin nerr++; $display("FAIL fwft_reset_dv got %b want 0", f_dv); end
        wr_en = 1; data_in = 8'hA5;
        step();
        wr_en = 0;
        nvec++; if (f_dv !== 1'b1 || f_dout !== 8'hA5) begin nerr++; $display("FAIL fwft_present got %h dv=%b want a5 dv=1", f_dout, f_dv); end
        rd_en = 1;
        step();
        rd_en = 0;
        nvec++; if (f_empty !== 1'b1 || f_dv !== 1'b0) begin nerr++; $display("FAIL fwft_pop got empty=%b dv=%b want 1/0", f_empty, f_dv); end
        nvec++; if (f_udf !== 1'b0) begin nerr++; $display("FAIL fwft_udf_early got %b want 0", f_udf); end
        rd_en = 1;
        step();
        rd_en = 0;
        nvec++; if (f_udf !== 1'b1) begin nerr++; $display("FAIL fwft_underflow got %b want 1", f_udf); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr_en = 1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'(i);
            step();
        end
        rd_en = 1;
        for (int i = 0; i < 20; i++) begin
            data_in = 8'(i + 4);
            step();
            nvec++; if (s_cnt !== 4'd4 || s_dout !== 8'(i) || s_dv !== 1'b1) begin nerr++; $display("FAIL b2b_%0d got cnt=%0d dout=%h dv=%b want 4/%h/1", i, s_cnt, s_dout, s_dv, 8'(i)); end
        end
        wr_en = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            nvec++; if (s_dout !== 8'(i + 20)) begin nerr++; $display("FAIL b2b_tail_%0d got %h want %h", i, s_dout, 8'(i + 20)); end
        end
        wr_en = 1; data_in = 8'h77;
        step();
        nvec++; if (s_cnt !== 4'd1 || s_udf !== 1'b1) begin nerr++; $display("FAIL empty_both got cnt=%0d udf=%b want 1/1", s_cnt, s_udf); end
        nvec++; if (s_dv !== 1'b0 || s_dout !== 8'h17) begin nerr++; $display("FAIL empty_both_rd got dv=%b dout=%h want 0/17", s_dv, s_dout); end
        wr_en = 0;
        step();
        rd_en = 0;
        nvec++; if (s_dout !== 8'h77 || s_dv !== 1'b1) begin nerr++; $display("FAIL empty_both_word got %h dv=%b want 77/1", s_dout, s_dv); end
    endtask

    task automatic test_thresholds();
        // almost_empty / almost_full after writes 1..4 with ae=1, af=6
        logic ae_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        af_thresh = 4'd6; ae_thresh = 4'd1;
        do_reset();
        nvec++; if (s_ae !== 1'b1) begin nerr++; $display("FAIL thr_ae0 got %b want 1", s_ae); end
        wr_en = 1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'(8'h40 + i);
            step();
            nvec++; if (s_ae !== ae_tab[i] || s_af !== 1'b0) begin nerr++; $display("FAIL thr_c%0d got ae=%b af=%b want ae=%b af=0", i + 1, s_ae, s_af, ae_tab[i]); end
        end
        wr_en = 0;
        af_thresh = 4'd3;
        #1;
        nvec++; if (s_af !== 1'b1) begin nerr++; $display("FAIL thr_live got af=%b want 1", s_af); end
        af_thresh = 4'd6;
        wr_en = 1;
        step();
        nvec++; if (s_af !== 1'b0) begin nerr++; $display("FAIL thr_c5 got af=%b want 0", s_af); end
        step();
        wr_en = 0;
        nvec++; if (s_af !== 1'b1 || s_cnt !== 4'd6) begin nerr++; $display("FAIL thr_c6 got af=%b cnt=%0d want 1/6", s_af, s_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        wr_en = 1;
        for (int i = 0; i < 9; i++) begin
            data_in = 8'(8'h30 + i);
            step();
        end
        wr_en = 0; rd_en = 1;
        for (int i = 0; i < 3; i++) step();
        rd_en = 0;
        nvec++; if (s_cnt !== 4'd5 || s_ovf !== 1'b1) begin nerr++; $display("FAIL pre_flush got cnt=%0d ovf=%b want 5/1", s_cnt, s_ovf); end
        flush = 1; wr_en = 1; data_in = 8'hEE;
        step();
        flush = 0; wr_en = 0;
        nvec++; if (s_cnt !== 4'd0 || s_empty !== 1'b1 || s_dv !== 1'b0) begin nerr++; $display("FAIL flush got cnt=%0d empty=%b dv=%b want 0/1/0", s_cnt, s_empty, s_dv); end
        nvec++; if (s_ovf !== 1'b1 || s_dout !== 8'h32) begin nerr++; $display("FAIL flush_keep got ovf=%b dout=%h want 1/32", s_ovf, s_dout); end
        rd_en = 1;
        step();
        rd_en = 0;
        nvec++; if (s_udf !== 1'b1) begin nerr++; $display("FAIL post_flush_udf got %b want 1", s_udf); end
        err_clr = 1;
        step();
        err_clr = 0;
        nvec++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin nerr++; $display("FAIL err_clr got %b%b want 00", s_ovf, s_udf); end
        err_clr = 1; rd_en = 1;
        step();
        err_clr = 0; rd_en = 0;
        nvec++; if (s_udf !== 1'b1 || s_ovf !== 1'b0) begin nerr++; $display("FAIL set_wins got udf=%b ovf=%b want 1/0", s_udf, s_ovf); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1; idle(); data_in = '0; af_thresh = 4'd6; ae_thresh = 4'd1;
        test_reset();
        test_fill_drain();
        test_fwft();
        test_back_to_back();
        test_thresholds();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
